// File: rtl/spi_master.sv
// SPI mode-0 master: LEAD / SHIFT / TRAIL / GAP framing around DATA_W bits, MSB first.
// done at 1+DIV*(2*DATA_W+2) cycles after accept; start is ignored while busy (no queuing).
module spi_master #(
  parameter int DATA_W = 8,
  parameter int DIV    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] txData,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rxData,
  output logic              sclk,
  output logic              ssel,
  output logic              mosi,
  input  logic              miso
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(2 * DATA_W - 1);
  localparam logic [BW-1:0] FALL_LAST = BW'(2 * DATA_W - 2);

  generate
    if (DIV < 2 || DIV > 255) begin : g_bad_div
      $error("spi_master: DIV must be in 2..255");
    end
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_width
      $error("spi_master: DATA_W must be in 2..32");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bits;
  logic [DATA_W-2:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rxData;
  logic              r_sclk;
  logic              r_ssel;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;
  logic              w_cnt_end;

  assign w_cnt_end = (r_cnt == CNT_LAST);

  // r_bits counts completed sclk half-periods inside SHIFT; even index = sclk high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rxData <= '0;
      r_sclk   <= 1'b0;
      r_ssel   <= 1'b1;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_tx    <= txData[DATA_W-2:0];
            r_mosi  <= txData[DATA_W-1];
            r_ssel  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_state <= LEAD;
          end
        end
        LEAD: begin
          if (w_cnt_end) begin
            // First rising edge happens on the LEAD->SHIFT transition.
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[DATA_W-2:0], miso};
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (w_cnt_end) begin
            r_cnt  <= '0;
            r_bits <= r_bits + BW'(1);
            if (r_bits == HALF_LAST) begin
              r_state <= TRAIL;
            end else begin
              r_sclk <= ~r_sclk;
              if (r_sclk) begin
                if (r_bits != FALL_LAST) begin
                  r_mosi <= r_tx[DATA_W-2];
                  r_tx   <= r_tx << 1;
                end
              end else begin
                r_rx <= {r_rx[DATA_W-2:0], miso};
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        TRAIL: begin
          if (w_cnt_end) begin
            r_cnt    <= '0;
            r_ssel   <= 1'b1;
            r_mosi   <= 1'b0;
            r_done   <= 1'b1;
            r_rxData <= r_rx;
            r_state  <= GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        GAP: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign rxData = r_rxData;
  assign sclk   = r_sclk;
  assign ssel   = r_ssel;
  assign mosi   = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an 8-bit/DIV=2 instance and a 16-bit/DIV=3 instance.
// Period p = value seen after the p-th clock edge following the accepting edge.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0;
  logic        start3 = 1'b0;
  logic [15:0] tx16 = '0;
  logic        miso_one = 1'b0;

  logic       busy8, done8, sclk8, ssel8, mosi8, miso8;
  logic [7:0] rx8;
  logic        busy3, done3, sclk3, ssel3, mosi3, miso3;
  logic [15:0] rx3;

  int n_cmp = 0;
  int n_err = 0;

  logic        h_ssel [0:255];
  logic        h_sclk [0:255];
  logic        h_mosi [0:255];
  logic        h_busy [0:255];
  logic        h_done [0:255];
  logic [15:0] h_rx   [0:255];

  always #5 clk = ~clk;

  assign miso8 = miso_one ? 1'b1 : mosi8;
  assign miso3 = mosi3;

  spi_master #(.DATA_W(8), .DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start8), .txData(tx16[7:0]),
    .busy(busy8), .done(done8), .rxData(rx8),
    .sclk(sclk8), .ssel(ssel8), .mosi(mosi8), .miso(miso8)
  );

  spi_master #(.DATA_W(16), .DIV(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .txData(tx16),
    .busy(busy3), .done(done3), .rxData(rx3),
    .sclk(sclk3), .ssel(ssel3), .mosi(mosi3), .miso(miso3)
  );

  task automatic record(input bit sel, input int p);
    h_ssel[p] = sel ? ssel3 : ssel8;
    h_sclk[p] = sel ? sclk3 : sclk8;
    h_mosi[p] = sel ? mosi3 : mosi8;
    h_busy[p] = sel ? busy3 : busy8;
    h_done[p] = sel ? done3 : done8;
    h_rx[p]   = sel ? rx3 : {8'h00, rx8};
  endtask

  // Present a request for the next edge (the accepting edge, period 0).
  task automatic kick(input bit sel, input logic [15:0] d);
    @(negedge clk);
    record(sel, 0);
    tx16   = d;
    start8 = !sel;
    start3 = sel;
  endtask

  // Record periods 1..n; optionally pulse start / reset at a given period.
  task automatic watch(input bit sel, input int n, input int pulse_at,
                       input logic [15:0] pulse_dat, input int rst_at, input bit hold);
    for (int p = 1; p <= n; p++) begin
      @(negedge clk);
      record(sel, p);
      start8 = !sel && (hold || p == pulse_at);
      start3 = sel && (hold || p == pulse_at);
      if (p == pulse_at) tx16 = pulse_dat;
      reset = (p == rst_at);
    end
    start8 = 1'b0;
    start3 = 1'b0;
    reset  = 1'b0;
  endtask

  function automatic int nth_done(input int n, input int k);
    int seen = 0;
    for (int p = 1; p <= n; p++)
      if (h_done[p] === 1'b1) begin
        seen++;
        if (seen == k) return p;
      end
    return -1;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int p = 1; p <= n; p++) if (h_done[p] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_rises(input int n);
    int c = 0;
    for (int p = 1; p <= n; p++) if (h_sclk[p] === 1'b1 && h_sclk[p-1] === 1'b0) c++;
    return c;
  endfunction

  function automatic logic [15:0] mosi_pat(input int n);
    logic [15:0] v = '0;
    for (int p = 1; p <= n; p++)
      if (h_sclk[p] === 1'b1 && h_sclk[p-1] === 1'b0) v = {v[14:0], h_mosi[p]};
    return v;
  endfunction

  function automatic int count_viol(input int n);
    int c = 0;
    for (int p = 1; p <= n; p++) begin
      if (h_ssel[p] === 1'b1 && h_sclk[p] !== h_sclk[p-1]) c++;
      if (h_sclk[p-1] === 1'b1 && h_ssel[p] !== h_ssel[p-1]) c++;
    end
    return c;
  endfunction

  // Number of periods in 1..n whose ssel differs from "low exactly in lo..hi".
  function automatic int ssel_window_err(input int n, input int lo, input int hi);
    int c = 0;
    for (int p = 1; p <= n; p++)
      if (h_ssel[p] !== ((p >= lo && p <= hi) ? 1'b0 : 1'b1)) c++;
    return c;
  endfunction

  task automatic test_reset;
    reset  = 1'b1;
    start8 = 1'b1;
    start3 = 1'b1;
    tx16   = 16'hFFFF;
    repeat (3) @(negedge clk);
    n_cmp++; if (ssel8 !== 1'b1) begin n_err++; $display("FAIL reset_ssel: got %0h want 1", ssel8); end
    n_cmp++; if (sclk8 !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %0h want 0", sclk8); end
    n_cmp++; if (mosi8 !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %0h want 0", mosi8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy_over_start: got %0h want 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0h want 0", done8); end
    n_cmp++; if (rx8 !== 8'h00) begin n_err++; $display("FAIL reset_rx: got %0h want 0", rx8); end
    n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL reset_busy3: got %0h want 0", busy3); end
    n_cmp++; if (ssel3 !== 1'b1) begin n_err++; $display("FAIL reset_ssel3: got %0h want 1", ssel3); end
    reset  = 1'b0;
    start8 = 1'b0;
    start3 = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: got %0h want 0", busy8); end
  endtask

  task automatic test_loopback;
    kick(0, 16'h00A5);
    watch(0, 45, -1, 16'h0, -1, 0);
    n_cmp++; if (h_mosi[1] !== 1'b1) begin n_err++; $display("FAIL lb_first_mosi: got %0h want 1", h_mosi[1]); end
    n_cmp++; if (nth_done(45, 1) !== 37) begin n_err++; $display("FAIL lb_done_cycle: got %0d want 37", nth_done(45, 1)); end
    n_cmp++; if (count_done(45) !== 1) begin n_err++; $display("FAIL lb_done_count: got %0d want 1", count_done(45)); end
    n_cmp++; if (h_rx[37] !== 16'h00A5) begin n_err++; $display("FAIL lb_rx: got %0h want a5", h_rx[37]); end
    n_cmp++; if (count_rises(45) !== 8) begin n_err++; $display("FAIL lb_rises: got %0d want 8", count_rises(45)); end
    n_cmp++; if (ssel_window_err(45, 1, 36) !== 0) begin n_err++; $display("FAIL lb_ssel_window: got %0d bad periods want 0", ssel_window_err(45, 1, 36)); end
    n_cmp++; if ({h_sclk[2], h_sclk[3], h_sclk[4], h_sclk[5], h_sclk[6]} !== 5'b01100)
      begin n_err++; $display("FAIL lb_sclk_phase: got %b want 01100", {h_sclk[2], h_sclk[3], h_sclk[4], h_sclk[5], h_sclk[6]}); end
    n_cmp++; if ({h_busy[38], h_busy[39]} !== 2'b10) begin n_err++; $display("FAIL lb_busy_fall: got %b want 10", {h_busy[38], h_busy[39]}); end
    n_cmp++; if (h_mosi[37] !== 1'b0) begin n_err++; $display("FAIL lb_gap_mosi: got %0h want 0", h_mosi[37]); end
    n_cmp++; if (count_viol(45) !== 0) begin n_err++; $display("FAIL lb_sclk_ssel_rule: got %0d want 0", count_viol(45)); end
    n_cmp++; if (h_rx[45] !== 16'h00A5) begin n_err++; $display("FAIL lb_rx_hold: got %0h want a5", h_rx[45]); end
  endtask

  task automatic test_miso_high;
    miso_one = 1'b1;
    kick(0, 16'h003C);
    watch(0, 45, -1, 16'h0, -1, 0);
    miso_one = 1'b0;
    n_cmp++; if (h_rx[37] !== 16'h00FF) begin n_err++; $display("FAIL m1_rx: got %0h want ff", h_rx[37]); end
    n_cmp++; if (mosi_pat(45) !== 16'h003C) begin n_err++; $display("FAIL m1_mosi_pattern: got %0h want 3c", mosi_pat(45)); end
    n_cmp++; if (h_mosi[1] !== 1'b0) begin n_err++; $display("FAIL m1_first_mosi: got %0h want 0", h_mosi[1]); end
  endtask

  task automatic test_start_ignored;
    kick(0, 16'h00A5);
    watch(0, 45, 10, 16'h0011, -1, 0);
    n_cmp++; if (count_done(45) !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", count_done(45)); end
    n_cmp++; if (nth_done(45, 1) !== 37) begin n_err++; $display("FAIL ign_done_cycle: got %0d want 37", nth_done(45, 1)); end
    n_cmp++; if (h_rx[37] !== 16'h00A5) begin n_err++; $display("FAIL ign_rx: got %0h want a5", h_rx[37]); end
    n_cmp++; if (h_busy[45] !== 1'b0) begin n_err++; $display("FAIL ign_no_queue: got %0h want 0", h_busy[45]); end
  endtask

  task automatic test_back_to_back;
    int hi;
    kick(0, 16'h005A);
    watch(0, 80, -1, 16'h0, -1, 1);
    hi = 0;
    for (int p = 1; p <= 75; p++) if (h_ssel[p] === 1'b1) hi++;
    n_cmp++; if (nth_done(80, 1) !== 37) begin n_err++; $display("FAIL b2b_done1: got %0d want 37", nth_done(80, 1)); end
    // Second accept happens at period 39 (IDLE), so its done lands 37 periods later.
    n_cmp++; if (nth_done(80, 2) !== 76) begin n_err++; $display("FAIL b2b_done2: got %0d want 76", nth_done(80, 2)); end
    n_cmp++; if (h_rx[37] !== 16'h005A) begin n_err++; $display("FAIL b2b_rx1: got %0h want 5a", h_rx[37]); end
    n_cmp++; if (h_rx[76] !== 16'h005A) begin n_err++; $display("FAIL b2b_rx2: got %0h want 5a", h_rx[76]); end
    n_cmp++; if (hi !== 3) begin n_err++; $display("FAIL b2b_ssel_gap: got %0d want 3", hi); end
    n_cmp++; if ({h_ssel[39], h_ssel[40]} !== 2'b10) begin n_err++; $display("FAIL b2b_relaunch: got %b want 10", {h_ssel[39], h_ssel[40]}); end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    kick(0, 16'h00A5);
    watch(0, 30, -1, 16'h0, 20, 0);
    n_cmp++; if (h_ssel[21] !== 1'b1) begin n_err++; $display("FAIL rm_ssel: got %0h want 1", h_ssel[21]); end
    n_cmp++; if (h_sclk[21] !== 1'b0) begin n_err++; $display("FAIL rm_sclk: got %0h want 0", h_sclk[21]); end
    n_cmp++; if (h_busy[21] !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %0h want 0", h_busy[21]); end
    n_cmp++; if (h_rx[21] !== 16'h0000) begin n_err++; $display("FAIL rm_rx: got %0h want 0", h_rx[21]); end
    n_cmp++; if (count_done(30) !== 0) begin n_err++; $display("FAIL rm_no_done: got %0d want 0", count_done(30)); end
    kick(0, 16'h00C3);
    watch(0, 45, -1, 16'h0, -1, 0);
    n_cmp++; if (nth_done(45, 1) !== 37) begin n_err++; $display("FAIL rm_after_done: got %0d want 37", nth_done(45, 1)); end
    n_cmp++; if (h_rx[37] !== 16'h00C3) begin n_err++; $display("FAIL rm_after_rx: got %0h want c3", h_rx[37]); end
  endtask

  task automatic test_div3_w16;
    kick(1, 16'hBEEF);
    watch(1, 110, -1, 16'h0, -1, 0);
    n_cmp++; if (nth_done(110, 1) !== 103) begin n_err++; $display("FAIL d3_done_cycle: got %0d want 103", nth_done(110, 1)); end
    n_cmp++; if (h_rx[103] !== 16'hBEEF) begin n_err++; $display("FAIL d3_rx: got %0h want beef", h_rx[103]); end
    n_cmp++; if (count_rises(110) !== 16) begin n_err++; $display("FAIL d3_rises: got %0d want 16", count_rises(110)); end
    n_cmp++; if ({h_sclk[3], h_sclk[4], h_sclk[6], h_sclk[7], h_sclk[9], h_sclk[10]} !== 6'b011001)
      begin n_err++; $display("FAIL d3_sclk_phase: got %b want 011001", {h_sclk[3], h_sclk[4], h_sclk[6], h_sclk[7], h_sclk[9], h_sclk[10]}); end
    n_cmp++; if (ssel_window_err(110, 1, 102) !== 0) begin n_err++; $display("FAIL d3_ssel_window: got %0d bad periods want 0", ssel_window_err(110, 1, 102)); end
    n_cmp++; if ({h_busy[105], h_busy[106]} !== 2'b10) begin n_err++; $display("FAIL d3_busy_fall: got %b want 10", {h_busy[105], h_busy[106]}); end
    n_cmp++; if (count_viol(110) !== 0) begin n_err++; $display("FAIL d3_sclk_ssel_rule: got %0d want 0", count_viol(110)); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_high();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_div3_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
